// File: rtl/spi_master_pkg.sv
// spi_master_pkg: shared types and opcode encodings for the SPI frame initiator.
//   state_e   : frame sequencer states
//   OP_*      : command opcodes carried in cmd[9:8]
package spi_master_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SEL,
      SHIFT,
      TURN,
      RECV,
      GAP
   } state_e;

   localparam logic [1:0] OP_WR_ADDR = 2'b00;
   localparam logic [1:0] OP_WR_DATA = 2'b01;
   localparam logic [1:0] OP_RD_ADDR = 2'b10;
   localparam logic [1:0] OP_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_master_drv.sv
// spi_master_drv: single-clock SPI frame initiator.
// Serialises a command word onto MOSI (select bit, then the full word MSB
// first) under SS_n; read-data commands are followed by a turnaround and an
// MSB-first reply capture from MISO. All outputs are registered.
// Ports:
//   clk, rst_n  : clock (posedge), asynchronous active-low reset
//   start, cmd  : launch request and command word (sampled only in IDLE)
//   busy        : frame in progress, including the inter-frame gap
//   done        : one-cycle pulse in the first gap cycle
//   rd_data     : last read reply, updated together with done
//   SS_n, MOSI  : slave select (active low) and serial command out
//   MISO        : serial reply in, sampled only while receiving
module spi_master_drv
   import spi_master_pkg::*;
#(
   parameter int CMD_W    = 10,
   parameter int DATA_W   = 8,
   parameter int TURN_CYC = 1,
   parameter int GAP_CYC  = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [CMD_W-1:0]  cmd,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] rd_data,
   output logic              SS_n,
   output logic              MOSI,
   input  logic              MISO
);

   localparam int CNT_W = 4;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [CMD_W-1:0]    tx_q, tx_d;
   logic [1:0]          op_q, op_d;
   logic [DATA_W-1:0]   rx_q, rx_d;
   logic [DATA_W-1:0]   rd_data_q, rd_data_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                ss_n_q, ss_n_d;
   logic                mosi_q, mosi_d;
   logic [DATA_W-1:0]   rx_shift;
   logic                go_gap;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         tx_q      <= '0;
         op_q      <= '0;
         rx_q      <= '0;
         rd_data_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         ss_n_q    <= 1'b1;
         mosi_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         tx_q      <= tx_d;
         op_q      <= op_d;
         rx_q      <= rx_d;
         rd_data_q <= rd_data_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         ss_n_q    <= ss_n_d;
         mosi_q    <= mosi_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      tx_d      = tx_q;
      op_d      = op_q;
      rx_d      = rx_q;
      rd_data_d = rd_data_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      ss_n_d    = ss_n_q;
      mosi_d    = 1'b0;
      go_gap    = 1'b0;
      rx_shift  = {rx_q[DATA_W-2:0], MISO};

      case (state_q)
         IDLE: begin
            ss_n_d = 1'b1;
            busy_d = 1'b0;
            if (start) begin
               state_d = SEL;
               tx_d    = cmd;
               op_d    = cmd[CMD_W-1 -: 2];
               busy_d  = 1'b1;
               ss_n_d  = 1'b0;
               mosi_d  = cmd[CMD_W-1];
            end
         end
         SEL: begin
            // The word itself starts here, so its MSB repeats the select bit.
            state_d = SHIFT;
            cnt_d   = CNT_W'(CMD_W - 1);
            mosi_d  = tx_q[CMD_W-1];
         end
         SHIFT: begin
            if (cnt_q == '0) begin
               case (op_q)
                  OP_RD_DATA: begin
                     state_d = TURN;
                     cnt_d   = CNT_W'(TURN_CYC - 1);
                  end
                  OP_WR_ADDR, OP_WR_DATA, OP_RD_ADDR: go_gap = 1'b1;
               endcase
            end else begin
               // MOSI registers one bit ahead of the shifted copy.
               cnt_d  = cnt_q - CNT_W'(1);
               tx_d   = {tx_q[CMD_W-2:0], 1'b0};
               mosi_d = tx_q[CMD_W-2];
            end
         end
         TURN: begin
            if (cnt_q == '0) begin
               state_d = RECV;
               cnt_d   = CNT_W'(DATA_W - 1);
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         RECV: begin
            rx_d = rx_shift;
            if (cnt_q == '0) begin
               rd_data_d = rx_shift;
               go_gap    = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         GAP: begin
            ss_n_d = 1'b1;
            if (cnt_q == '0) begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            ss_n_d  = 1'b1;
         end
      endcase

      if (go_gap) begin
         state_d = GAP;
         cnt_d   = CNT_W'(GAP_CYC - 1);
         ss_n_d  = 1'b1;
         done_d  = 1'b1;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign rd_data = rd_data_q;
   assign SS_n    = ss_n_q;
   assign MOSI    = mosi_q;

endmodule

// File: tb/tb_spi_master_drv.sv
// tb_spi_master_drv: directed bench for spi_master_drv with a behavioural
// SPI slave + RAM model that decodes the MOSI stream and answers reads.
module tb_spi_master_drv;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [9:0] cmd = '0;
   logic       busy, done, ss_n, mosi;
   logic       miso = 1'b0;
   logic [7:0] rd_data;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   spi_master_drv #(.CMD_W(10), .DATA_W(8), .TURN_CYC(1), .GAP_CYC(1)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .cmd(cmd),
      .busy(busy), .done(done), .rd_data(rd_data),
      .SS_n(ss_n), .MOSI(mosi), .MISO(miso)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Slave model: k counts SS_n-low cycles (0 = select bit, 1..10 = word,
   // 11 = turnaround, 12..19 = reply).
   int         k = 0, hi_run = 0, last_gap = 0, last_len = 0;
   int         frame_cnt = 0, done_cnt = 0, idle_mosi_err = 0;
   logic [10:0] bits = '0;
   logic [9:0]  sreg = '0;
   logic [7:0]  addr = '0, reply = '0;
   logic [7:0]  mem [256];
   logic        force_en = 1'b0;
   logic [7:0]  force_val = '0;

   always @(negedge clk) begin
      logic [7:0] r;
      r = force_en ? force_val : reply;
      if (done) done_cnt++;
      if (ss_n) begin
         if (mosi) idle_mosi_err++;
         if (k > 0) begin
            last_len = k;
            frame_cnt++;
         end
         k = 0;
         hi_run++;
         miso = 1'b0;
      end else begin
         if (k == 0) begin
            last_gap = hi_run;
            bits = '0;
         end
         hi_run = 0;
         if (k <= 10) bits = {bits[9:0], mosi};
         if (k >= 1 && k <= 10) sreg = {sreg[8:0], mosi};
         if (k == 10) begin
            case (sreg[9:8])
               2'b00: addr = sreg[7:0];
               2'b01: mem[addr] = sreg[7:0];
               2'b10: reply = mem[sreg[7:0]];
               default: ;
            endcase
         end
         if (k >= 12 && k <= 19) miso = r[19-k];
         else miso = (k == 11);   // junk in turnaround must be ignored
         k++;
      end
   end

   task automatic tick;
      @(negedge clk);
      #1;
   endtask

   task automatic launch(input logic [9:0] c);
      tick;
      start = 1'b1;
      cmd   = c;
      tick;
      start = 1'b0;
      cmd   = ~c;
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      do begin
         tick;
         n++;
      end while (!done && n < 60);
      chk({tag, "_done"}, done, 1);
   endtask

   initial begin
      int fc0, d0, n;

      // 1: reset holds everything idle, start ignored
      for (int i = 0; i < 3; i++) begin
         tick;
         start = ~start;
         #1;
         chk("rst_ss", ss_n, 1);
         chk("rst_mosi", mosi, 0);
         chk("rst_busy", busy, 0);
         chk("rst_done", done, 0);
         chk("rst_rd", rd_data, 0);
      end
      start = 1'b0;
      tick;
      rst_n = 1'b1;
      tick;
      chk("post_rst_busy", busy, 0);

      // 2: write address 0x0A5
      launch(10'h0A5);
      wait_done("wa");
      chk("wa_ss_at_done", ss_n, 1);
      chk("wa_len", last_len, 11);
      chk("wa_bits", bits, 11'h0A5);
      chk("wa_done_cnt", done_cnt, 1);
      tick;
      chk("wa_done_pulse", done, 0);
      chk("wa_busy_low", busy, 0);

      // 3: read data with slave reply 0xC3, then a write keeps rd_data
      force_en  = 1'b1;
      force_val = 8'hC3;
      launch(10'h3FF);
      wait_done("rd");
      chk("rd_data", rd_data, 8'hC3);
      chk("rd_len", last_len, 20);
      chk("rd_bits", bits, 11'h7FF);
      force_en = 1'b0;
      launch(10'h155);
      wait_done("wd");
      chk("wd_keep_rd", rd_data, 8'hC3);
      chk("wd_len", last_len, 11);
      chk("wd_bits", bits, 11'h155);

      // 4: start held high -> GAP cycle plus the IDLE cycle between frames
      tick;
      start = 1'b1;
      cmd   = 10'h100;
      wait_done("b2b1");
      wait_done("b2b2");
      n = 0;
      while (ss_n && n < 10) begin
         tick;
         n++;
      end
      chk("b2b_restart", ss_n, 0);
      chk("b2b_gap", last_gap, 2);
      start = 1'b0;
      wait_done("b2b3");
      chk("b2b_bits", bits, 11'h100);
      chk("b2b_len", last_len, 11);

      // start pulsed mid-frame is ignored
      fc0 = frame_cnt;
      launch(10'h0C3);
      repeat (4) tick;
      start = 1'b1;
      cmd   = 10'h2AA;
      tick;
      start = 1'b0;
      wait_done("mid");
      repeat (5) tick;
      chk("mid_frames", frame_cnt - fc0, 1);
      chk("mid_bits", bits, 11'h0C3);
      chk("mid_busy", busy, 0);

      // 5: asynchronous reset in the middle of SHIFT
      d0 = done_cnt;
      launch(10'h0A5);
      repeat (5) tick;
      rst_n = 1'b0;
      #1;
      chk("arst_ss", ss_n, 1);
      chk("arst_busy", busy, 0);
      chk("arst_mosi", mosi, 0);
      chk("arst_rd", rd_data, 0);
      repeat (3) tick;
      chk("arst_no_done", done_cnt, d0);
      rst_n = 1'b1;
      tick;
      launch(10'h1A5);
      wait_done("arec");
      chk("arec_len", last_len, 11);
      chk("arec_bits", bits, 11'h1A5);

      // 6: loopback through the slave RAM model
      launch(10'h012);
      wait_done("lb_wa");
      launch(10'h15A);
      wait_done("lb_wd");
      launch(10'h212);
      wait_done("lb_ra");
      launch(10'h300);
      wait_done("lb_rd");
      chk("lb_rd_data", rd_data, 8'h5A);
      chk("lb_len", last_len, 20);

      tick;
      chk("idle_mosi", idle_mosi_err, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
